// File: rtl/seek_timing_emulator.sv
// RK05 head-motion timing model: per-cylinder travel, settle, seek_done pulse on arrival.
// Defining SEEK_FAST_EN shrinks each travel and settle interval to a single us tick.
module seek_timing_emulator #(
  parameter int TICK_DIV   = 40,
  parameter int PER_CYL_US = 400,
  parameter int BASE_US    = 5000
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       Selected_Ready,
  input  logic       seek_start,
  input  logic [7:0] Target_Cylinder,
  output logic [7:0] Current_Cylinder,
  output logic       seek_busy,
  output logic       seek_done,
  output logic       BUS_RWS_RDY_H,
  output logic       oncylinder_ind
);

`ifdef SEEK_FAST_EN
  localparam int PER_TICKS  = 1;
  localparam int BASE_TICKS = 1;
`else
  localparam int PER_TICKS  = PER_CYL_US;
  localparam int BASE_TICKS = BASE_US;
`endif

  localparam logic [5:0]  DIV_LAST  = 6'(TICK_DIV - 1);
  localparam logic [15:0] PER_LAST  = 16'(PER_TICKS - 1);
  localparam logic [15:0] BASE_LAST = 16'(BASE_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_MOVE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_presc;
  logic [15:0] r_us;
  logic [7:0]  r_delta;
  logic        r_dir_up;

  logic        w_accept;
  logic        w_tick;
  logic        w_per_exp;
  logic        w_base_exp;
  logic        w_interval_end;
  logic        w_target_up;
  logic [7:0]  w_delta_in;

  assign w_accept       = seek_start && Selected_Ready && (Target_Cylinder <= 8'd202);
  assign w_tick         = (r_presc == DIV_LAST);
  assign w_per_exp      = w_tick && (r_us == PER_LAST);
  assign w_base_exp     = w_tick && (r_us == BASE_LAST);
  assign w_interval_end = ((r_state == S_MOVE) && w_per_exp) ||
                          ((r_state == S_SETTLE) && w_base_exp);
  assign w_target_up    = (Target_Cylinder > Current_Cylinder);
  assign w_delta_in     = w_target_up ? (Target_Cylinder - Current_Cylinder)
                                      : (Current_Cylinder - Target_Cylinder);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_CALC;
      S_CALC:   w_next = (r_delta == 8'd0) ? S_DONE : S_MOVE;
      S_MOVE:   if (w_per_exp && (r_delta == 8'd1)) w_next = S_SETTLE;
      S_SETTLE: if (w_base_exp) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    // Losing the drive mid-seek abandons the motion without an arrival pulse.
    if ((r_state != S_IDLE) && !Selected_Ready) w_next = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state          <= S_IDLE;
      r_presc          <= 6'd0;
      r_us             <= 16'd0;
      r_delta          <= 8'd0;
      r_dir_up         <= 1'b0;
      Current_Cylinder <= 8'd0;
      seek_busy        <= 1'b0;
      seek_done        <= 1'b0;
      BUS_RWS_RDY_H    <= 1'b0;
      oncylinder_ind   <= 1'b1;
    end else begin
      r_state        <= w_next;
      seek_busy      <= (w_next != S_IDLE);
      seek_done      <= (w_next == S_DONE);
      BUS_RWS_RDY_H  <= Selected_Ready && (w_next == S_IDLE);
      oncylinder_ind <= (r_state == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_delta  <= w_delta_in;
            r_dir_up <= w_target_up;
          end
        end
        S_CALC: begin
          r_presc <= 6'd0;
          r_us    <= 16'd0;
        end
        S_MOVE, S_SETTLE: begin
          if (w_tick) begin
            r_presc <= 6'd0;
            r_us    <= w_interval_end ? 16'd0 : r_us + 16'd1;
          end else begin
            r_presc <= r_presc + 6'd1;
          end
          // An abort sampled on the same edge as a step leaves the heads where they were.
          if ((r_state == S_MOVE) && w_per_exp && Selected_Ready) begin
            Current_Cylinder <= r_dir_up ? Current_Cylinder + 8'd1 : Current_Cylinder - 8'd1;
            r_delta          <= r_delta - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seek_timing_emulator.sv
// Scoreboard bench for seek_timing_emulator with shortened interval parameters.
module tb_seek_timing_emulator;

  localparam int TD   = 4;
  localparam int PER  = 3;
  localparam int BASE = 5;
`ifdef SEEK_FAST_EN
  localparam int PT = TD;
  localparam int BT = TD;
`else
  localparam int PT = TD * PER;
  localparam int BT = TD * BASE;
`endif

  logic       clock = 1'b0;
  logic       reset_L;
  logic       Selected_Ready;
  logic       seek_start;
  logic [7:0] Target_Cylinder;
  logic [7:0] Current_Cylinder;
  logic       seek_busy;
  logic       seek_done;
  logic       BUS_RWS_RDY_H;
  logic       oncylinder_ind;

  seek_timing_emulator #(.TICK_DIV(TD), .PER_CYL_US(PER), .BASE_US(BASE)) dut (
    .clock(clock), .reset_L(reset_L), .Selected_Ready(Selected_Ready),
    .seek_start(seek_start), .Target_Cylinder(Target_Cylinder),
    .Current_Cylinder(Current_Cylinder), .seek_busy(seek_busy), .seek_done(seek_done),
    .BUS_RWS_RDY_H(BUS_RWS_RDY_H), .oncylinder_ind(oncylinder_ind)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  logic sel_d = 1'b0;
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    sel_d <= Selected_Ready && reset_L;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of the most recent accepted seek; position and timing follow from plain arithmetic.
  int m_from = 0, m_delta = 0, m_up = 0, m_c0 = -1000, m_L = 2, m_ab = 0, m_ab_cyc = 0;

  typedef struct {
    int done_cyc;
    int cyl;
  } exp_t;
  exp_t q[$];

  function automatic int exp_cyl(input int c);
    int k, steps;
    k = ((m_ab != 0) && (c > m_ab_cyc) ? m_ab_cyc : c) - m_c0 - 2;
    steps = (k < 0) ? 0 : k / PT;
    if (steps > m_delta) steps = m_delta;
    return (m_up != 0) ? m_from + steps : m_from - steps;
  endfunction

  function automatic bit window(input int c);
    return (c >= m_c0 + 1) && (c <= m_c0 + m_L) && !((m_ab != 0) && (c > m_ab_cyc));
  endfunction

  task automatic seek(input int t);
    int from;
    exp_t e;
    @(negedge clock);
    seek_start      = 1'b1;
    Target_Cylinder = 8'(t);
    if (Selected_Ready && !window(cyc) && t <= 202) begin
      from    = exp_cyl(cyc);
      m_from  = from;
      m_up    = (t > from) ? 1 : 0;
      m_delta = (t > from) ? t - from : from - t;
      m_c0    = cyc;
      m_ab    = 0;
      m_L     = (m_delta == 0) ? 2 : 2 + m_delta * PT + BT;
      e.done_cyc = m_c0 + m_L;
      e.cyl      = t;
      q.push_back(e);
    end
    @(negedge clock);
    seek_start      = 1'b0;
    Target_Cylinder = 8'($urandom_range(0, 255));
  endtask

  task automatic drop_ready();
    @(negedge clock);
    Selected_Ready = 1'b0;
    if ((m_ab == 0) && (cyc >= m_c0 + 1) && (cyc <= m_c0 + m_L - 1)) begin
      m_ab     = 1;
      m_ab_cyc = cyc;
      if (q.size() > 0) void'(q.pop_back());
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (window(cyc) && guard < 20000) begin
      @(negedge clock);
      guard++;
    end
    repeat (3) @(negedge clock);
  endtask

  // Monitor: pops the scoreboard on each seek_done and cross-checks outputs when they move.
  bit   mon_en = 1'b0;
  logic [7:0] p_cyl = 'x;
  int   p_ecyl = -1;
  logic p_rws = 'x, p_busy = 'x, p_onc = 'x;
  bit   p_erws = 1'b0, p_ebusy = 1'b0, p_eonc = 1'b0;
  exp_t e_mon;

  always begin
    @(posedge clock);
    #1;
    if (mon_en) begin
      if (q.size() > 0 && cyc > q[0].done_cyc) begin
        chk("seek_done_timeout", 0, 1);
        void'(q.pop_front());
      end
      if (seek_done) begin
        if (q.size() == 0) begin
          chk("unexpected_seek_done", 1, 0);
        end else begin
          e_mon = q.pop_front();
          chk("done_cycle", cyc, e_mon.done_cyc);
          chk("done_cylinder", int'(Current_Cylinder), e_mon.cyl);
          chk("done_busy", int'(seek_busy), 1);
          chk("done_rws", int'(BUS_RWS_RDY_H), 0);
        end
      end
      if (Current_Cylinder !== p_cyl || exp_cyl(cyc) != p_ecyl)
        chk("cylinder", int'(Current_Cylinder), exp_cyl(cyc));
      if (BUS_RWS_RDY_H !== p_rws || (sel_d && !window(cyc)) != p_erws)
        chk("rws_rdy", int'(BUS_RWS_RDY_H), int'(sel_d && !window(cyc)));
      if (seek_busy !== p_busy || window(cyc) != p_ebusy)
        chk("busy", int'(seek_busy), int'(window(cyc)));
      if (oncylinder_ind !== p_onc || !window(cyc - 1) != p_eonc)
        chk("oncyl", int'(oncylinder_ind), int'(!window(cyc - 1)));
      p_cyl   = Current_Cylinder;
      p_ecyl  = exp_cyl(cyc);
      p_rws   = BUS_RWS_RDY_H;
      p_erws  = sel_d && !window(cyc);
      p_busy  = seek_busy;
      p_ebusy = window(cyc);
      p_onc   = oncylinder_ind;
      p_eonc  = !window(cyc - 1);
    end
  end

  initial begin
    reset_L         = 1'b0;
    Selected_Ready  = 1'b1;
    seek_start      = 1'b0;
    Target_Cylinder = 8'd0;
    repeat (3) @(negedge clock);
    chk("rst_cylinder", int'(Current_Cylinder), 0);
    chk("rst_busy", int'(seek_busy), 0);
    chk("rst_done", int'(seek_done), 0);
    chk("rst_rws", int'(BUS_RWS_RDY_H), 0);
    chk("rst_oncyl", int'(oncylinder_ind), 1);
    reset_L = 1'b1;
    mon_en  = 1'b1;
    @(negedge clock);
    chk("rws_after_release", int'(BUS_RWS_RDY_H), 1);

    seek(10);
    wait_idle();
    chk("cyl_after_0_to_10", int'(Current_Cylinder), 10);

    seek(10);
    wait_idle();

    seek(202);
    repeat (30) @(negedge clock);
    seek(50);
    wait_idle();
    chk("cyl_after_ignored_second", int'(Current_Cylinder), 202);

    seek(0);
    wait_idle();

    seek(100);
    repeat (3 * PT + 1) @(negedge clock);
    drop_ready();
    repeat (2) @(negedge clock);
    chk("abort_cylinder", int'(Current_Cylinder), 3);
    chk("abort_busy", int'(seek_busy), 0);
    chk("abort_rws", int'(BUS_RWS_RDY_H), 0);
    repeat (BT + 10) @(negedge clock);
    seek(20);
    repeat (5) @(negedge clock);
    chk("not_ready_ignored", int'(seek_busy), 0);
    Selected_Ready = 1'b1;
    repeat (2) @(negedge clock);
    seek(250);
    repeat (5) @(negedge clock);
    chk("bad_target_ignored", int'(seek_busy), 0);

    for (int i = 0; i < 14; i++) begin
      seek($urandom_range(0, 210));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 20)) @(negedge clock);
        seek($urandom_range(0, 202));
      end
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 60)) @(negedge clock);
        drop_ready();
        repeat ($urandom_range(2, 8)) @(negedge clock);
        Selected_Ready = 1'b1;
      end
      wait_idle();
    end

    repeat (10) @(negedge clock);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
